// File: rtl/muldiv_ctrl.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) controller.
// Optional abort input enabled by defining MULDIV_ABORT_EN.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
`ifdef MULDIV_ABORT_EN
    input  logic        abort,
`endif
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hi_we,
    output logic        lo_we
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] a_q;
    logic [32:0] acc_q;
    logic [31:0] q_q;
    logic        qm1_q;
    logic        qneg_q;
    logic        rneg_q;
    logic        busy_q, done_q, div0_q, hi_we_q, lo_we_q;
    logic [31:0] hi_q, lo_q;

    logic        abort_w;
    logic [31:0] abs_a, abs_b;
    logic [32:0] booth_d;
    logic [32:0] rem_sh, rem_diff;
    logic [31:0] quot_fix, rem_fix;

`ifdef MULDIV_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign abs_a    = op_a[31] ? (32'd0 - op_a) : op_a;
    assign abs_b    = op_b[31] ? (32'd0 - op_b) : op_b;
    assign rem_sh   = {acc_q[31:0], q_q[31]};
    assign rem_diff = rem_sh - {1'b0, a_q};
    assign quot_fix = qneg_q ? (32'd0 - q_q) : q_q;
    assign rem_fix  = rneg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];

    // Accumulator is one bit wider so -2^31 operands cannot overflow
    always_comb begin
        booth_d = acc_q;
        case ({q_q[0], qm1_q})
            2'b01:   booth_d = acc_q + {a_q[31], a_q};
            2'b10:   booth_d = acc_q - {a_q[31], a_q};
            default: booth_d = acc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_we_q <= 1'b0;
            lo_we_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_we_q <= 1'b0;
            lo_we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_mult) begin
                        a_q     <= op_a;
                        q_q     <= op_b;
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MULT;
                    end else if (start_div) begin
                        if (op_b == 32'd0) begin
                            div0_q <= 1'b1;
                        end else begin
                            a_q     <= abs_b;
                            q_q     <= abs_a;
                            acc_q   <= '0;
                            qneg_q  <= op_a[31] ^ op_b[31];
                            rneg_q  <= op_a[31];
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= DIV;
                        end
                    end
                end
                MULT: begin
                    if (abort_w) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == 6'd32) begin
                        hi_q    <= acc_q[31:0];
                        lo_q    <= q_q;
                        done_q  <= 1'b1;
                        hi_we_q <= 1'b1;
                        lo_we_q <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        acc_q <= {booth_d[32], booth_d[32:1]};
                        q_q   <= {booth_d[0], q_q[31:1]};
                        qm1_q <= q_q[0];
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DIV: begin
                    if (abort_w) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == 6'd32) begin
                        hi_q    <= rem_fix;
                        lo_q    <= quot_fix;
                        done_q  <= 1'b1;
                        hi_we_q <= 1'b1;
                        lo_we_q <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        if (!rem_diff[32]) begin
                            acc_q <= rem_diff;
                            q_q   <= {q_q[30:0], 1'b1};
                        end else begin
                            acc_q <= rem_sh;
                            q_q   <= {q_q[30:0], 1'b0};
                        end
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign div0  = div0_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign hi_we = hi_we_q;
    assign lo_we = lo_we_q;

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 32-bit operands and a 64-bit product.
REQ-002 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide port start_mult, input, 1 bit: request a signed multiply, sampled in IDLE only.
REQ-005 SHALL provide port start_div, input, 1 bit: request a signed divide, sampled in IDLE only.
REQ-006 SHALL provide port op_a, input, 32 bits: multiplicand or dividend (A register value).
REQ-007 SHALL provide port op_b, input, 32 bits: multiplier or divisor (B register value).
REQ-008 SHALL provide port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL provide port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 SHALL provide port div0, output, 1 bit: one-cycle pulse on divide-by-zero.
REQ-011 SHALL provide port hi, output, 32 bits: upper product word or remainder.
REQ-012 SHALL provide port lo, output, 32 bits: lower product word or quotient.
REQ-013 SHALL provide ports hi_we and lo_we, output, 1 bit each: write enables for the HI and LO holding registers.

Function
REQ-014 SHALL implement the states IDLE, MULT, DIV and FIN.
REQ-015 In IDLE, start_mult=1 SHALL capture op_a/op_b, clear the iteration counter, and enter MULT.
REQ-016 In IDLE, start_div=1 with start_mult=0 SHALL capture op_a/op_b and enter DIV; when both are high, start_mult SHALL win.
REQ-017 MULT SHALL perform radix-2 Booth signed multiplication, one iteration per cycle, 32 iterations, then enter FIN.
REQ-018 DIV SHALL perform restoring division on operand magnitudes, one quotient bit per cycle, 32 iterations, then sign-correct and enter FIN.
REQ-019 Divide sign rules SHALL be: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-020 op_a=0x80000000 with op_b=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no exception.
REQ-021 Division with op_b=0 SHALL pulse div0 in the cycle after the start is sampled, assert neither done nor hi_we/lo_we, leave hi/lo unchanged, and return to IDLE.
REQ-022 FIN SHALL last one cycle: done=1, hi_we=lo_we=1, hi/lo hold the result, then return to IDLE.
REQ-023 Latency SHALL be fixed: start sampled at edge N gives done high in the cycle after edge N+33.
REQ-024 busy SHALL be high in MULT, DIV and FIN, and low in IDLE.
REQ-025 start_mult and start_div SHALL be ignored outside IDLE; a request is not queued.
REQ-026 Operand changes after capture SHALL NOT affect the result.
REQ-027 hi and lo SHALL hold the last result until the next FIN.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE and set busy=done=div0=hi_we=lo_we=0, hi=lo=0x00000000, and counter=0.
REQ-029 Reset during MULT or DIV SHALL abandon the operation with no done or write-enable pulse.
REQ-030 Operation SHALL resume at the first rising clk edge after reset deasserts.

Configuration
REQ-031 With macro MULDIV_ABORT_EN defined, the block SHALL add input port abort (1 bit); abort=1 in MULT or DIV SHALL return to IDLE at the next edge with no done, no write enables, and hi/lo unchanged; abort in IDLE or FIN SHALL have no effect.
REQ-032 Without MULDIV_ABORT_EN, the abort port and its logic SHALL be absent, and operations always run to completion.

Verification
REQ-033 Multiply 7 x -3 (0x00000007, 0xFFFFFFFD) -> done 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; hi_we=lo_we=1 for 1 cycle.
REQ-034 Divide -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divide 100 / 7 -> lo=0x0000000E, hi=0x00000002.
REQ-035 Divide 5 / 0 -> div0 pulses 1 cycle after start; done, hi_we and lo_we stay 0; previous hi/lo are retained; busy low next cycle.
REQ-036 Divide 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000; div0=0.
REQ-037 start_div pulsed at cycle 10 of a multiply, and both starts asserted together in IDLE -> the mid-operation request is ignored, the multiply result is correct, and the multiply is selected.
REQ-038 reset low at cycle 15 of a divide -> all outputs 0 immediately; no done; a new multiply 3 x 4 then yields hi=0x00000000, lo=0x0000000C. With MULDIV_ABORT_EN defined, abort at cycle 15 -> no done, prior hi/lo retained.
